// File: rtl/wash_pkg.sv
// Shared codes for the washer timing stage: controller state codes, run phases and program selects.
package wash_pkg;

   localparam logic [2:0] shutDownST = 3'd0;
   localparam logic [2:0] beginST    = 3'd1;
   localparam logic [2:0] setST      = 3'd2;
   localparam logic [2:0] runST      = 3'd3;
   localparam logic [2:0] errorST    = 3'd4;
   localparam logic [2:0] pauseST    = 3'd5;
   localparam logic [2:0] finishST   = 3'd6;

   localparam logic [1:0] PH_IDLE  = 2'd0;
   localparam logic [1:0] PH_WASH  = 2'd1;
   localparam logic [1:0] PH_RINSE = 2'd2;
   localparam logic [1:0] PH_SPIN  = 2'd3;

   localparam logic [1:0] PROG_STD        = 2'd0;
   localparam logic [1:0] PROG_QUICK      = 2'd1;
   localparam logic [1:0] PROG_RINSE_SPIN = 2'd2;
   localparam logic [1:0] PROG_SPIN       = 2'd3;

   // run, pause and error share one timing context: moving among them keeps the prescaler position
   function automatic logic in_run_context(input logic [2:0] st);
      return (st == runST) || (st == pauseST) || (st == errorST);
   endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second tick generator: counts enabled cycles and pulses tick for one cycle at terminal count.
module sec_prescaler #(
   parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
   input  logic cp,
   input  logic resetBtn,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

   if (TICKS_PER_SEC < 1) begin : g_bad_ticks
      $error("sec_prescaler: TICKS_PER_SEC must be at least 1");
   end

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = en && !clr && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge cp or negedge resetBtn) begin
      if (!resetBtn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wash_phase_timer.sv
// Washer timing stage: self-test/finish countdowns, WASH->RINSE->SPIN sequencing, actuator enables.
// Defining WASH_BUZZER_EN adds a buzzer output that toggles on every second tick in the finish state.
module wash_phase_timer
   import wash_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 50_000_000,
   parameter int unsigned INIT_SEC      = 3,
   parameter int unsigned FINISH_SEC    = 5,
   parameter int unsigned WASH_SEC      = 60,
   parameter int unsigned RINSE_SEC     = 40,
   parameter int unsigned SPIN_SEC      = 30,
   parameter int unsigned FILL_SEC      = 5
) (
   input  logic       cp,
   input  logic       resetBtn,
   input  logic [2:0] state,
   input  logic [1:0] progSel,
   output logic [2:0] initTime,
   output logic [2:0] finishTime,
   output logic       hadFinish,
   output logic [1:0] phase,
   output logic [7:0] remainSec,
   output logic       motorOn,
   output logic       waterIn,
   output logic       drainOn
`ifdef WASH_BUZZER_EN
   ,
   output logic       buzzer
`endif
);

   if (INIT_SEC < 1 || INIT_SEC > 7 || FINISH_SEC < 1 || FINISH_SEC > 7) begin : g_bad_countdown
      $error("wash_phase_timer: INIT_SEC and FINISH_SEC must be 1..7");
   end
   if (WASH_SEC + RINSE_SEC + SPIN_SEC > 255 || FILL_SEC > 255) begin : g_bad_duration
      $error("wash_phase_timer: program total and FILL_SEC must fit in 8 bits");
   end

   localparam logic [2:0] INIT_V    = 3'(INIT_SEC);
   localparam logic [2:0] FINISH_V  = 3'(FINISH_SEC);
   localparam logic [7:0] WASH_V    = 8'(WASH_SEC);
   localparam logic [7:0] RINSE_V   = 8'(RINSE_SEC);
   localparam logic [7:0] SPIN_V    = 8'(SPIN_SEC);
   localparam logic [7:0] FILL_V    = 8'(FILL_SEC);
   localparam logic [7:0] FILL_HALF = ((FILL_V >> 1) == 8'd0) ? 8'd1 : (FILL_V >> 1);

   logic [2:0] prev_state_q, prev_state_d;
   logic [2:0] init_q, init_d;
   logic [2:0] finish_q, finish_d;
   logic       had_finish_q, had_finish_d;
   logic [1:0] phase_q, phase_d;
   logic [7:0] remain_q, remain_d;
   logic [7:0] wash_dur_q, wash_dur_d;
   logic [7:0] rinse_dur_q, rinse_dur_d;
   logic [7:0] spin_dur_q, spin_dur_d;
   logic [7:0] fill_q, fill_d;

   logic       presc_clr, presc_en, tick;
   logic       in_run;
   logic [7:0] cur_dur;

   // Restart the second on a real mode change; pause/error/run hops keep the count so resume is exact
   assign presc_clr = (state != prev_state_q) &&
                      !(in_run_context(state) && in_run_context(prev_state_q));
   assign presc_en  = (state == beginST) || (state == runST) || (state == finishST);

   sec_prescaler #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_prescaler (
      .cp      (cp),
      .resetBtn(resetBtn),
      .clr     (presc_clr),
      .en      (presc_en),
      .tick    (tick)
   );

   always_comb begin
      prev_state_d = state;
      init_d       = INIT_V;
      finish_d     = FINISH_V;
      if (state == beginST) begin
         init_d = (tick && init_q != 3'd0) ? init_q - 3'd1 : init_q;
      end
      if (state == finishST) begin
         finish_d = (tick && finish_q != 3'd0) ? finish_q - 3'd1 : finish_q;
      end
   end

   always_comb begin
      had_finish_d = had_finish_q;
      phase_d      = phase_q;
      remain_d     = remain_q;
      wash_dur_d   = wash_dur_q;
      rinse_dur_d  = rinse_dur_q;
      spin_dur_d   = spin_dur_q;
      fill_d       = fill_q;
      case (state)
         setST: begin
            wash_dur_d   = WASH_V;
            rinse_dur_d  = RINSE_V;
            spin_dur_d   = SPIN_V;
            fill_d       = FILL_V;
            case (progSel)
               PROG_STD: ;
               PROG_QUICK: begin
                  wash_dur_d  = WASH_V >> 1;
                  rinse_dur_d = RINSE_V >> 1;
                  spin_dur_d  = SPIN_V >> 1;
                  fill_d      = FILL_HALF;
               end
               PROG_RINSE_SPIN: wash_dur_d = 8'd0;
               default: begin
                  wash_dur_d  = 8'd0;
                  rinse_dur_d = 8'd0;
               end
            endcase
            had_finish_d = 1'b0;
            phase_d      = PH_IDLE;
            remain_d     = 8'd0;
         end
         runST: begin
            if (phase_q == PH_IDLE) begin
               if (prev_state_q == setST) begin
                  if (wash_dur_q != 8'd0) begin
                     phase_d  = PH_WASH;
                     remain_d = wash_dur_q;
                  end else if (rinse_dur_q != 8'd0) begin
                     phase_d  = PH_RINSE;
                     remain_d = rinse_dur_q;
                  end else if (spin_dur_q != 8'd0) begin
                     phase_d  = PH_SPIN;
                     remain_d = spin_dur_q;
                  end else begin
                     had_finish_d = 1'b1;
                  end
               end
            end else if (remain_q == 8'd0) begin
               // A later zero-length phase is entered and left again on the next cycle
               case (phase_q)
                  PH_WASH: begin
                     phase_d  = PH_RINSE;
                     remain_d = rinse_dur_q;
                  end
                  PH_RINSE: begin
                     phase_d  = PH_SPIN;
                     remain_d = spin_dur_q;
                  end
                  default: begin
                     phase_d      = PH_IDLE;
                     had_finish_d = 1'b1;
                  end
               endcase
            end else if (tick) begin
               remain_d = remain_q - 8'd1;
            end
         end
         beginST, errorST, pauseST, finishST: ;
         default: begin
            had_finish_d = 1'b0;
            phase_d      = PH_IDLE;
            remain_d     = 8'd0;
         end
      endcase
   end

   always_ff @(posedge cp or negedge resetBtn) begin
      if (!resetBtn) begin
         prev_state_q <= shutDownST;
         init_q       <= INIT_V;
         finish_q     <= FINISH_V;
         had_finish_q <= 1'b0;
         phase_q      <= PH_IDLE;
         remain_q     <= 8'd0;
         wash_dur_q   <= 8'd0;
         rinse_dur_q  <= 8'd0;
         spin_dur_q   <= 8'd0;
         fill_q       <= 8'd0;
      end else begin
         prev_state_q <= prev_state_d;
         init_q       <= init_d;
         finish_q     <= finish_d;
         had_finish_q <= had_finish_d;
         phase_q      <= phase_d;
         remain_q     <= remain_d;
         wash_dur_q   <= wash_dur_d;
         rinse_dur_q  <= rinse_dur_d;
         spin_dur_q   <= spin_dur_d;
         fill_q       <= fill_d;
      end
   end

   always_comb begin
      cur_dur = 8'd0;
      case (phase_q)
         PH_WASH:  cur_dur = wash_dur_q;
         PH_RINSE: cur_dur = rinse_dur_q;
         default:  ;
      endcase
   end

   always_comb begin
      remainSec = 8'd0;
      case (phase_q)
         PH_WASH:  remainSec = remain_q + rinse_dur_q + spin_dur_q;
         PH_RINSE: remainSec = remain_q + spin_dur_q;
         PH_SPIN:  remainSec = remain_q;
         default:  ;
      endcase
   end

   assign in_run     = (state == runST);
   assign motorOn    = in_run && (phase_q != PH_IDLE);
   assign drainOn    = in_run && (phase_q == PH_SPIN);
   assign waterIn    = in_run && (cur_dur != 8'd0) && ((cur_dur - remain_q) < fill_q);
   assign initTime   = init_q;
   assign finishTime = finish_q;
   assign hadFinish  = had_finish_q;
   assign phase      = phase_q;

`ifdef WASH_BUZZER_EN
   logic buzzer_q, buzzer_d;

   always_comb begin
      buzzer_d = 1'b0;
      if (state == finishST) begin
         buzzer_d = tick ? !buzzer_q : buzzer_q;
      end
   end

   always_ff @(posedge cp or negedge resetBtn) begin
      if (!resetBtn) begin
         buzzer_q <= 1'b0;
      end else begin
         buzzer_q <= buzzer_d;
      end
   end

   assign buzzer = buzzer_q;
`endif

endmodule

// File: tb/tb_wash_phase_timer.sv
// Self-checking bench for wash_phase_timer: spec-level model compared every cycle plus literal checkpoints.
module tb_wash_phase_timer;

   localparam int TPS      = 4;
   localparam int INIT_S   = 3;
   localparam int FINISH_S = 5;
   localparam int WASH_S   = 6;
   localparam int RINSE_S  = 4;
   localparam int SPIN_S   = 3;
   localparam int FILL_S   = 2;

   logic       cp;
   logic       resetBtn;
   logic [2:0] state;
   logic [1:0] progSel;
   logic [2:0] initTime;
   logic [2:0] finishTime;
   logic       hadFinish;
   logic [1:0] phase;
   logic [7:0] remainSec;
   logic       motorOn;
   logic       waterIn;
   logic       drainOn;
`ifdef WASH_BUZZER_EN
   logic       buzzer;
`endif

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   // Model state: seconds bookkeeping in plain integers, phase durations indexed 1..3
   int         m_cnt;
   logic [2:0] m_prev;
   int         m_init;
   int         m_finish;
   bit         m_done;
   int         m_ph;
   int         m_rem;
   int         m_dur[0:3];
   int         m_fill;
   bit         m_buzz;

   wash_phase_timer #(
      .TICKS_PER_SEC(TPS),
      .INIT_SEC     (INIT_S),
      .FINISH_SEC   (FINISH_S),
      .WASH_SEC     (WASH_S),
      .RINSE_SEC    (RINSE_S),
      .SPIN_SEC     (SPIN_S),
      .FILL_SEC     (FILL_S)
   ) dut (
      .cp        (cp),
      .resetBtn  (resetBtn),
      .state     (state),
      .progSel   (progSel),
      .initTime  (initTime),
      .finishTime(finishTime),
      .hadFinish (hadFinish),
      .phase     (phase),
      .remainSec (remainSec),
      .motorOn   (motorOn),
      .waterIn   (waterIn),
      .drainOn   (drainOn)
`ifdef WASH_BUZZER_EN
      ,
      .buzzer    (buzzer)
`endif
   );

   initial cp = 1'b0;
   always #5 cp = ~cp;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   function automatic bit run_family(input logic [2:0] s);
      return (s == 3'd3) || (s == 3'd4) || (s == 3'd5);
   endfunction

   task automatic model_reset();
      m_cnt    = 0;
      m_prev   = 3'd0;
      m_init   = INIT_S;
      m_finish = FINISH_S;
      m_done   = 0;
      m_ph     = 0;
      m_rem    = 0;
      m_fill   = 0;
      m_buzz   = 0;
      for (int p = 0; p <= 3; p++) m_dur[p] = 0;
   endtask

   task automatic model_step();
      bit clr, en, tk;
      if (!resetBtn) begin
         model_reset();
         return;
      end
      clr = (state != m_prev) && !(run_family(state) && run_family(m_prev));
      en  = (state == 3'd1) || (state == 3'd3) || (state == 3'd6);
      tk  = en && !clr && (m_cnt == TPS - 1);
      if (clr) m_cnt = 0;
      else if (en) m_cnt = tk ? 0 : m_cnt + 1;

      if (state != 3'd1) m_init = INIT_S;
      else if (tk && m_init > 0) m_init = m_init - 1;
      if (state != 3'd6) m_finish = FINISH_S;
      else if (tk && m_finish > 0) m_finish = m_finish - 1;
      if (state != 3'd6) m_buzz = 0;
      else if (tk) m_buzz = !m_buzz;

      case (state)
         3'd2: begin
            m_dur[1] = WASH_S;
            m_dur[2] = RINSE_S;
            m_dur[3] = SPIN_S;
            m_fill   = FILL_S;
            if (progSel == 2'd1) begin
               for (int p = 1; p <= 3; p++) m_dur[p] = m_dur[p] / 2;
               m_fill = (FILL_S / 2 > 0) ? FILL_S / 2 : 1;
            end
            if (progSel >= 2'd2) m_dur[1] = 0;
            if (progSel == 2'd3) m_dur[2] = 0;
            m_done = 0;
            m_ph   = 0;
            m_rem  = 0;
         end
         3'd3: begin
            if (m_ph == 0) begin
               if (m_prev == 3'd2) begin
                  for (int p = 1; p <= 3; p++) begin
                     if (m_ph == 0 && m_dur[p] > 0) begin
                        m_ph  = p;
                        m_rem = m_dur[p];
                     end
                  end
                  if (m_ph == 0) m_done = 1;
               end
            end else if (m_rem == 0) begin
               if (m_ph == 3) begin
                  m_ph   = 0;
                  m_done = 1;
               end else begin
                  m_ph  = m_ph + 1;
                  m_rem = m_dur[m_ph];
               end
            end else if (tk) begin
               m_rem = m_rem - 1;
            end
         end
         3'd1, 3'd4, 3'd5, 3'd6: ;
         default: begin
            m_done = 0;
            m_ph   = 0;
            m_rem  = 0;
         end
      endcase
      m_prev = state;
   endtask

   function automatic int exp_remain();
      int s;
      if (m_ph == 0) return 0;
      s = m_rem;
      for (int p = m_ph + 1; p <= 3; p++) s += m_dur[p];
      return s;
   endfunction

   function automatic logic [19:0] exp_outputs();
      logic mot, wat, drn;
      int   d;
      mot = (state == 3'd3) && (m_ph != 0);
      drn = (state == 3'd3) && (m_ph == 3);
      d   = (m_ph == 1 || m_ph == 2) ? m_dur[m_ph] : 0;
      wat = (state == 3'd3) && (d > 0) && ((d - m_rem) < m_fill);
      return {3'(m_init), 3'(m_finish), m_done, 2'(m_ph), 8'(exp_remain()), mot, wat, drn};
   endfunction

   always @(negedge cp) begin
      if (chk_en) begin
         check("cycle_outputs",
               int'({initTime, finishTime, hadFinish, phase, remainSec, motorOn, waterIn, drainOn}),
               int'(exp_outputs()));
`ifdef WASH_BUZZER_EN
         check("cycle_buzzer", int'(buzzer), int'(m_buzz));
`endif
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge cp);
         model_step();
         #1;
      end
   endtask

   initial begin
      resetBtn = 1'b0;
      state    = 3'd0;
      progSel  = 2'd0;
      model_reset();
      chk_en   = 1;
      step(3);
      resetBtn = 1'b1;
      step(2);
      check("reset_initTime", initTime, 3);
      check("reset_finishTime", finishTime, 5);
      check("reset_hadFinish", hadFinish, 0);
      check("reset_remainSec", remainSec, 0);
      check("reset_phase", phase, 0);

      // Self-test countdown: first tick four cycles after the first begin edge
      state = 3'd1;
      step(4);  check("init_before_tick", initTime, 3);
      step(1);  check("init_first_tick", initTime, 2);
      step(8);  check("init_zero", initTime, 0);
      step(8);  check("init_saturate", initTime, 0);

      // Standard program end to end
      state = 3'd2; progSel = 2'd0;
      step(2);
      state = 3'd3;
      step(1);  check("std_phase_wash", phase, 1);
                check("std_remain_13", remainSec, 13);
                check("std_water_on", waterIn, 1);
                check("std_motor_on", motorOn, 1);
      step(7);  check("std_water_last", waterIn, 1);
      step(1);  check("std_water_off", waterIn, 0);
                check("std_remain_11", remainSec, 11);
      step(16); check("std_wash_zero", phase, 1);
                check("std_remain_7", remainSec, 7);
      step(1);  check("std_phase_rinse", phase, 2);
                check("std_rinse_water", waterIn, 1);
      step(16); check("std_phase_spin", phase, 3);
                check("std_drain_on", drainOn, 1);
                check("std_remain_3", remainSec, 3);
      step(11); check("std_not_done", hadFinish, 0);
      step(1);  check("std_done", hadFinish, 1);
                check("std_idle", phase, 0);
                check("std_motor_off", motorOn, 0);

      // Pause then error for 20 cycles after 3 s: completion slips by exactly 20 cycles
      state = 3'd2;
      step(2);  check("set_clears_done", hadFinish, 0);
      state = 3'd3;
      step(13); check("pause_pre_remain", remainSec, 10);
      state = 3'd5;
      step(10); check("pause_remain", remainSec, 10);
                check("pause_motor", motorOn, 0);
                check("pause_phase", phase, 1);
      state = 3'd4;
      step(10); check("error_remain", remainSec, 10);
      state = 3'd3;
      step(40); check("slip_not_done", hadFinish, 0);
      step(1);  check("slip_done", hadFinish, 1);

      // Spin-only program
      state = 3'd2; progSel = 2'd3;
      step(2);
      state = 3'd3;
      step(1);  check("spin_phase", phase, 3);
                check("spin_remain", remainSec, 3);
                check("spin_drain", drainOn, 1);
      step(12); check("spin_not_done", hadFinish, 0);
      step(1);  check("spin_done", hadFinish, 1);

      // Finish alert countdown
      state = 3'd6;
      step(1);  check("fin_start", finishTime, 5);
                check("fin_keep_done", hadFinish, 1);
      step(4);  check("fin_first_tick", finishTime, 4);
`ifdef WASH_BUZZER_EN
                check("fin_buzzer_on", buzzer, 1);
`endif
      step(16); check("fin_zero", finishTime, 0);
      step(4);  check("fin_saturate", finishTime, 0);
      state = 3'd7;
      step(1);  check("illegal_clears", hadFinish, 0);

      // Quick program: halved durations and fill
      state = 3'd2; progSel = 2'd1;
      step(2);
      state = 3'd3;
      step(1);  check("quick_remain", remainSec, 6);
                check("quick_water_on", waterIn, 1);
      step(4);  check("quick_water_off", waterIn, 0);
                check("quick_remain_5", remainSec, 5);

      // Rinse+spin program, then asynchronous reset mid-run
      state = 3'd2; progSel = 2'd2;
      step(2);
      state = 3'd3;
      step(1);  check("rs_phase", phase, 2);
                check("rs_remain", remainSec, 7);
      step(9);
      resetBtn = 1'b0;
      model_reset();
      #2;
      check("async_phase", phase, 0);
      check("async_remain", remainSec, 0);
      check("async_motor", motorOn, 0);
      check("async_init", initTime, 3);
      step(2);
      resetBtn = 1'b1;
      step(6);  check("no_resume_phase", phase, 0);
                check("no_resume_motor", motorOn, 0);

      state = 3'd0;
      step(2);
      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
